// File: rtl/bip_uart_system.sv
// bip_uart_system
//    BIP-I accumulator processor with a fixed program ROM and data RAM, a lock
//    sequencer, and an 8N1 UART transmitter. After lock and reset release the
//    core runs the program once. On HLT it sends the accumulator, low byte first.
//
//    Ports:
//       i_clk      system clock, rising edge
//       i_rst      synchronous active-high system reset
//       i_rst_clk  synchronous active-high lock-sequencer reset
//       o_tx       UART serial output, idles high
//       o_locked   high once the lock sequencer has completed
//
//    Build option:
//       SEND_PC_EN  when defined, a third frame carries the halt PC,
//                   zero-extended to 8 bits.
//
//    TX FSM states:
//       state | meaning
//       IDLE  | line high; waits for a pending byte and a baud tick
//       START | start bit (low) for 16 ticks
//       DATA  | DBIT data bits, LSB first, 16 ticks each
//       STOP  | stop bit (high) for SBTICK ticks, then the next byte or IDLE
module bip_uart_system #(
   parameter int NBITS_O     = 11,
   parameter int NBITS_E     = 5,
   parameter int NBITS_D     = 16,
   parameter int OPCODE      = 5,
   parameter int CELDAS      = 10,
   parameter int DBIT        = 8,
   parameter int SBTICK      = 16,
   parameter int SIZ         = 8,
   parameter int DIV         = 6,
   parameter int LOCK_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_rst_clk,
   output logic o_tx,
   output logic o_locked
);

   localparam int AW = $clog2(CELDAS);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam int SW = $clog2(SBTICK);
   localparam int NW = $clog2(DBIT);
`ifdef SEND_PC_EN
   localparam int NBYTES = 3;
`else
   localparam int NBYTES = 2;
`endif
   localparam int PW = NBYTES * DBIT;

   localparam logic [LW-1:0]      LOCK_N   = LW'(LOCK_CYCLES);
   localparam logic [NBITS_E-1:0] CELDAS_E = NBITS_E'(CELDAS);
   localparam logic [SIZ-1:0]     BAUD_TOP = SIZ'(DIV - 1);
   localparam logic [SW-1:0]      BIT_TOP  = SW'(15);
   localparam logic [SW-1:0]      STOP_TOP = SW'(SBTICK - 1);
   localparam logic [NW-1:0]      DBIT_TOP = NW'(DBIT - 1);
   localparam logic [1:0]         NB       = 2'(NBYTES);

   localparam logic [OPCODE-1:0] OP_HLT  = 5'd0;
   localparam logic [OPCODE-1:0] OP_STO  = 5'd1;
   localparam logic [OPCODE-1:0] OP_LD   = 5'd2;
   localparam logic [OPCODE-1:0] OP_LDI  = 5'd3;
   localparam logic [OPCODE-1:0] OP_ADD  = 5'd4;
   localparam logic [OPCODE-1:0] OP_ADDI = 5'd5;
   localparam logic [OPCODE-1:0] OP_SUB  = 5'd6;
   localparam logic [OPCODE-1:0] OP_SUBI = 5'd7;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   // ---------------- lock sequencer ----------------
   logic [LW-1:0] lock_cnt;
   logic          locked;

   always_ff @(posedge i_clk) begin
      if (i_rst_clk) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (lock_cnt != LOCK_N) begin
         lock_cnt <= lock_cnt + 1'b1;
         locked   <= (lock_cnt == LOCK_N - 1'b1);
      end
   end

   logic rst_core;
   assign rst_core = i_rst | ~locked;

   // ---------------- baud tick ----------------
   logic [SIZ-1:0] baud_cnt;
   logic           tick;
   assign tick = (baud_cnt == BAUD_TOP);

   always_ff @(posedge i_clk) begin
      if (rst_core || tick) baud_cnt <= '0;
      else                  baud_cnt <= baud_cnt + 1'b1;
   end

   // ---------------- core ----------------
   function automatic logic [NBITS_D-1:0] rom_word(input logic [NBITS_E-1:0] a);
      case (a)
         0:       rom_word = {OP_LDI,  11'h123};
         1:       rom_word = {OP_STO,  11'h000};
         2:       rom_word = {OP_ADDI, 11'h0F0};
         3:       rom_word = {OP_ADD,  11'h000};
         4:       rom_word = {OP_SUBI, 11'h006};
         5:       rom_word = {OP_STO,  11'h001};
         6:       rom_word = {OP_LD,   11'h001};
         7:       rom_word = {OP_SUB,  11'h000};
         default: rom_word = {OP_HLT,  11'h000};   // includes PC >= CELDAS
      endcase
   endfunction

   logic [NBITS_E-1:0] pc;
   logic [NBITS_D-1:0] acc;
   logic               halted;
   logic [NBITS_D-1:0] ram [CELDAS];

   logic [NBITS_D-1:0] instr;
   logic [OPCODE-1:0]  opcode;
   logic [NBITS_O-1:0] operand;
   logic [NBITS_D-1:0] imm;
   logic [NBITS_E-1:0] addr;
   logic               addr_ok;
   logic [NBITS_D-1:0] mem_rd;

   assign instr   = rom_word(pc);
   assign opcode  = instr[NBITS_D-1:NBITS_O];
   assign operand = instr[NBITS_O-1:0];
   assign imm     = {{(NBITS_D-NBITS_O){operand[NBITS_O-1]}}, operand};
   assign addr    = operand[NBITS_E-1:0];
   assign addr_ok = (addr < CELDAS_E);
   assign mem_rd  = addr_ok ? ram[addr[AW-1:0]] : '0;

   always_ff @(posedge i_clk) begin
      if (rst_core) begin
         pc     <= '0;
         acc    <= '0;
         halted <= 1'b0;
         for (int i = 0; i < CELDAS; i++) ram[i] <= '0;
      end else if (!halted) begin
         pc <= pc + 1'b1;
         case (opcode)
            OP_HLT: begin
               pc     <= pc;
               halted <= 1'b1;
            end
            OP_STO:  if (addr_ok) ram[addr[AW-1:0]] <= acc;
            OP_LD:   acc <= mem_rd;
            OP_LDI:  acc <= imm;
            OP_ADD:  acc <= acc + mem_rd;
            OP_ADDI: acc <= acc + imm;
            OP_SUB:  acc <= acc - mem_rd;
            OP_SUBI: acc <= acc - imm;
            default: ;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   logic [PW-1:0] pay_val;
`ifdef SEND_PC_EN
   assign pay_val = {{(DBIT-NBITS_E){1'b0}}, pc, acc};
`else
   assign pay_val = acc;
`endif

   tx_state_t     state, state_n;
   logic [SW-1:0] s_cnt, s_n;
   logic [NW-1:0] n_cnt, n_n;
   logic [1:0]    b_left, b_left_n;
   logic [DBIT-1:0] sh, sh_n;
   logic [PW-1:0] pay, pay_n;
   logic          sent, sent_n;
   logic          tx_reg, tx_n;

   always_ff @(posedge i_clk) begin
      if (rst_core) begin
         state  <= S_IDLE;
         s_cnt  <= '0;
         n_cnt  <= '0;
         b_left <= '0;
         sh     <= '0;
         pay    <= '0;
         sent   <= 1'b0;
         tx_reg <= 1'b1;
      end else begin
         state  <= state_n;
         s_cnt  <= s_n;
         n_cnt  <= n_n;
         b_left <= b_left_n;
         sh     <= sh_n;
         pay    <= pay_n;
         sent   <= sent_n;
         tx_reg <= tx_n;
      end
   end

   always_comb begin
      state_n  = state;
      s_n      = s_cnt;
      n_n      = n_cnt;
      b_left_n = b_left;
      sh_n     = sh;
      pay_n    = pay;
      sent_n   = sent;

      // Latch happens once; b_left is zero until then so it never collides
      // with the byte-load below.
      if (halted && !sent) begin
         sent_n   = 1'b1;
         pay_n    = pay_val;
         b_left_n = NB;
      end

      case (state)
         S_IDLE: begin
            // Waiting for a tick keeps every bit, including the first start
            // bit, exactly 16 ticks long.
            if (b_left != 2'd0 && tick) begin
               state_n  = S_START;
               s_n      = '0;
               sh_n     = pay[DBIT-1:0];
               pay_n    = pay >> DBIT;
               b_left_n = b_left - 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               if (s_cnt == BIT_TOP) begin
                  state_n = S_DATA;
                  s_n     = '0;
                  n_n     = '0;
               end else begin
                  s_n = s_cnt + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (s_cnt == BIT_TOP) begin
                  s_n  = '0;
                  sh_n = sh >> 1;
                  if (n_cnt == DBIT_TOP) state_n = S_STOP;
                  else                   n_n = n_cnt + 1'b1;
               end else begin
                  s_n = s_cnt + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (s_cnt == STOP_TOP) begin
                  s_n = '0;
                  if (b_left != 2'd0) begin
                     state_n  = S_START;
                     sh_n     = pay[DBIT-1:0];
                     pay_n    = pay >> DBIT;
                     b_left_n = b_left - 1'b1;
                  end else begin
                     state_n = S_IDLE;
                  end
               end else begin
                  s_n = s_cnt + 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      case (state_n)
         S_START: tx_n = 1'b0;
         S_DATA:  tx_n = sh_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   assign o_tx     = tx_reg;
   assign o_locked = locked;

endmodule

// File: tb/tb_bip_uart_system.sv
// tb_bip_uart_system
//    Self-checking bench for bip_uart_system. A reference interpreter runs the
//    program image at the instruction level to produce the expected bytes; a
//    16x-oversampled receiver decodes o_tx. Reset points and hold times are
//    randomised.
module tb_bip_uart_system;

   localparam int DIV         = 6;
   localparam int LOCK_CYCLES = 16;
   localparam int BT          = 16 * DIV;     // clocks per bit
`ifdef SEND_PC_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif

   logic i_clk = 1'b0;
   logic i_rst;
   logic i_rst_clk;
   logic o_tx;
   logic o_locked;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_b [NB];

   bip_uart_system dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rst_clk (i_rst_clk),
      .o_tx      (o_tx),
      .o_locked  (o_locked)
   );

   always #50 i_clk = ~i_clk;    // 10 MHz

   initial begin
      #(100 * 100000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Instruction-level reference: walk the program until HLT.
   task automatic build_model();
      logic [15:0] prog [10];
      logic [15:0] ram  [10];
      logic [15:0] acc, imm, rd;
      logic [4:0]  op, a;
      int          pc;
      prog[0] = {5'd3, 11'h123};
      prog[1] = {5'd1, 11'h000};
      prog[2] = {5'd5, 11'h0F0};
      prog[3] = {5'd4, 11'h000};
      prog[4] = {5'd7, 11'h006};
      prog[5] = {5'd1, 11'h001};
      prog[6] = {5'd2, 11'h001};
      prog[7] = {5'd6, 11'h000};
      prog[8] = 16'h0000;
      prog[9] = 16'h0000;
      for (int i = 0; i < 10; i++) ram[i] = 16'h0;
      acc = 16'h0;
      pc  = 0;
      while (pc < 10 && prog[pc][15:11] != 5'd0) begin
         op  = prog[pc][15:11];
         a   = prog[pc][4:0];
         imm = {{5{prog[pc][10]}}, prog[pc][10:0]};
         rd  = (a < 10) ? ram[a] : 16'h0;
         case (op)
            5'd1: if (a < 10) ram[a] = acc;
            5'd2: acc = rd;
            5'd3: acc = imm;
            5'd4: acc = acc + rd;
            5'd5: acc = acc + imm;
            5'd6: acc = acc - rd;
            5'd7: acc = acc - imm;
            default: ;
         endcase
         pc++;
      end
      exp_b[0] = acc[7:0];
      exp_b[1] = acc[15:8];
`ifdef SEND_PC_EN
      exp_b[2] = 8'(pc);
`endif
   endtask

   // Waits (bounded) for a start bit, then samples mid-bit. rise is the
   // number of clocks the line stayed low from the falling edge.
   task automatic rx_frame(output logic [7:0] b, output int t_fall,
                           output int rise, output bit ok);
      int   n;
      logic st, sp;
      b = 8'h0; rise = -1; ok = 1'b0; t_fall = 0; st = 1'b1; sp = 1'b0;
      n = 0;
      while (o_tx !== 1'b0 && n < 5000) begin
         @(negedge i_clk); n++;
      end
      if (o_tx !== 1'b0) return;
      t_fall = $time / 100;
      for (int c = 1; c <= 9 * BT + BT / 2; c++) begin
         @(negedge i_clk);
         if (rise < 0 && o_tx === 1'b1) rise = c;
         if (c % BT == BT / 2) begin
            if (c / BT == 0)      st = o_tx;
            else if (c / BT == 9) sp = o_tx;
            else                  b[c / BT - 1] = o_tx;
         end
      end
      ok = (st === 1'b0) && (sp === 1'b1);
   endtask

   task automatic full_rx(input string tag);
      logic [7:0] b;
      int t, tp, rise, tz, lows;
      bit ok;
      tp = 0;
      for (int i = 0; i < NB; i++) begin
         rx_frame(b, t, rise, ok);
         chk({tag, "_frame"}, int'(ok), 1);
         chk({tag, "_byte"}, int'(b), int'(exp_b[i]));
         if (i == 0) begin
            tz = 0;
            while (tz < 8 && exp_b[0][tz] == 1'b0) tz++;
            chk({tag, "_startw"}, rise, BT * (1 + tz));
         end else begin
            chk({tag, "_period"}, t - tp, 10 * BT);
         end
         tp = t;
      end
      lows = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge i_clk);
         if (o_tx !== 1'b1) lows++;
      end
      chk({tag, "_quiet"}, lows, 0);
   endtask

   task automatic wait_lock(input string tag);
      int  k;
      bit  hi;
      k = 0; hi = 1'b1;
      while (o_locked !== 1'b1 && k < 100) begin
         @(posedge i_clk); #1; k++;
         if (o_tx !== 1'b1) hi = 1'b0;
      end
      chk({tag, "_lat"}, k, LOCK_CYCLES);
      chk({tag, "_tx"}, int'(hi), 1);
   endtask

   initial begin
      int  n, bitn, off;
      bit  got;
      i_rst     = 1'b1;
      i_rst_clk = 1'b1;
      build_model();

      repeat (5) @(negedge i_clk);
      chk("rst_locked", int'(o_locked), 0);
      chk("rst_tx", int'(o_tx), 1);

      i_rst_clk = 1'b0;
      wait_lock("lock");
      repeat ($urandom_range(1, 20)) @(negedge i_clk);
      chk("held_tx", int'(o_tx), 1);
      i_rst = 1'b0;
      full_rx("run");

      for (int it = 0; it < 2; it++) begin
         i_rst = 1'b1;
         repeat ($urandom_range(2, 8)) @(negedge i_clk);
         i_rst = 1'b0;
         n = 0;
         while (o_tx !== 1'b0 && n < 5000) begin
            @(negedge i_clk); n++;
         end
         got = (o_tx === 1'b0);
         chk("mf_start", int'(got), 1);
         // 0x0D has zero bits 4..7, so the line is low where reset lands
         bitn = $urandom_range(4, 7);
         off  = $urandom_range(2, BT - 3);
         repeat (BT * (1 + bitn) + off) @(negedge i_clk);
         chk("mf_pre", int'(o_tx), int'(exp_b[0][bitn]));
         i_rst = 1'b1;
         @(posedge i_clk); #1;
         chk("mf_tx_hi", int'(o_tx), 1);
         repeat ($urandom_range(1, 10)) @(negedge i_clk);
         i_rst = 1'b0;
         full_rx("mf");
      end

      @(negedge i_clk);
      i_rst_clk = 1'b1;
      @(posedge i_clk); #1;
      chk("ll_locked", int'(o_locked), 0);
      repeat ($urandom_range(2, 6)) @(negedge i_clk);
      chk("ll_tx", int'(o_tx), 1);
      i_rst_clk = 1'b0;
      wait_lock("relock");
      full_rx("ll");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
